// File: rtl/red_selecting_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : red_selecting_light_fsm
//  Description : Per-cell setup-phase cursor FSM for one red LED of the
//                Game-of-Life board. Optional macro RED_CURSOR_HOME_EN makes
//                this the home cell that holds the cursor out of reset.
//  Revision    : 1.0  initial release
// ============================================================================
module red_selecting_light_fsm (
  input  logic clk,
  input  logic reset,
  input  logic l,
  input  logic a,
  input  logic r,
  input  logic b,
  input  logic leftButton,
  input  logic rightButton,
  input  logic upButton,
  input  logic downButton,
  input  logic startGameSwitch,
  output logic redLED
);

  typedef enum logic [1:0] {
    SETUP_OFF = 2'b00,
    SETUP_ON  = 2'b01,
    IN_GAME   = 2'b10
  } state_t;

`ifdef RED_CURSOR_HOME_EN
  localparam state_t C_RESET_STATE = SETUP_ON;
`else
  localparam state_t C_RESET_STATE = SETUP_OFF;
`endif

  state_t r_state;
  state_t w_next;
  logic   r_redLED;

  logic w_only_left;
  logic w_only_right;
  logic w_only_up;
  logic w_only_down;
  logic w_one_btn;
  logic w_enter;

  assign w_only_left  =  leftButton & ~rightButton & ~upButton & ~downButton;
  assign w_only_right = ~leftButton &  rightButton & ~upButton & ~downButton;
  assign w_only_up    = ~leftButton & ~rightButton &  upButton & ~downButton;
  assign w_only_down  = ~leftButton & ~rightButton & ~upButton &  downButton;
  assign w_one_btn    = w_only_left | w_only_right | w_only_up | w_only_down;

  // Cursor arrives from the neighbour on the side opposite the move direction.
  assign w_enter = (w_only_left & r) | (w_only_right & l) |
                   (w_only_down & a) | (w_only_up & b);

  always_comb begin
    w_next = SETUP_OFF;
    case (r_state)
      SETUP_OFF: begin
        if (startGameSwitch)  w_next = IN_GAME;
        else if (w_enter)     w_next = SETUP_ON;
        else                  w_next = SETUP_OFF;
      end
      SETUP_ON: begin
        if (startGameSwitch)  w_next = IN_GAME;
        else if (w_one_btn)   w_next = SETUP_OFF;
        else                  w_next = SETUP_ON;
      end
      IN_GAME:   w_next = IN_GAME;
      default:   w_next = SETUP_OFF;
    endcase
  end

  // Output register tracks the state register so redLED is a pure Moore decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= C_RESET_STATE;
      r_redLED <= (C_RESET_STATE == SETUP_ON);
    end else begin
      r_state  <= w_next;
      r_redLED <= (w_next == SETUP_ON);
    end
  end

  assign redLED = r_redLED;

endmodule
`default_nettype wire

// File: tb/tb_red_selecting_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_red_selecting_light_fsm
//  Description : Directed and random stimulus for red_selecting_light_fsm,
//                checked against a cursor/lock reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_red_selecting_light_fsm;

  logic clk = 1'b0;
  logic reset, l, a, r, b;
  logic leftButton, rightButton, upButton, downButton, startGameSwitch;
  logic redLED;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RED_CURSOR_HOME_EN
  localparam bit C_HOME = 1'b1;
`else
  localparam bit C_HOME = 1'b0;
`endif

  // Reference model: does this cell hold the cursor, and has the game begun.
  bit m_cursor;
  bit m_locked;

  red_selecting_light_fsm u_dut (
    .clk             (clk),
    .reset           (reset),
    .l               (l),
    .a               (a),
    .r               (r),
    .b               (b),
    .leftButton      (leftButton),
    .rightButton     (rightButton),
    .upButton        (upButton),
    .downButton      (downButton),
    .startGameSwitch (startGameSwitch),
    .redLED          (redLED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: redLED=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step(input bit rst, input bit start,
                                     input bit [3:0] btn, input bit [3:0] nb);
    int presses;
    if (rst) begin
      m_cursor = C_HOME;
      m_locked = 1'b0;
      return;
    end
    if (m_locked) return;
    if (start) begin
      m_locked = 1'b1;
      m_cursor = 1'b0;
      return;
    end
    presses = $countones(btn);
    if (presses != 1) return;
    if (m_cursor) m_cursor = 1'b0;
    else begin
      // left press pulls from right neighbour, right from left, up from below, down from above
      case (btn)
        4'b1000: m_cursor = nb[1];
        4'b0100: m_cursor = nb[3];
        4'b0010: m_cursor = nb[0];
        4'b0001: m_cursor = nb[2];
        default: m_cursor = 1'b0;
      endcase
    end
  endfunction

  // btn = {left,right,up,down}, nb = {l,a,r,b}; one clock edge per call.
  task automatic step(input string tag, input bit rst, input bit start,
                      input bit [3:0] btn, input bit [3:0] nb);
    reset = rst; startGameSwitch = start;
    {leftButton, rightButton, upButton, downButton} = btn;
    {l, a, r, b} = nb;
    @(posedge clk);
    #1;
    model_step(rst, start, btn, nb);
    check(tag, redLED, m_cursor & ~m_locked);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 4'b0000, 4'b0000);
  endtask

  initial begin
    m_cursor = 1'b0;
    m_locked = 1'b0;
    reset = 1'b1; startGameSwitch = 1'b0;
    {leftButton, rightButton, upButton, downButton} = 4'b0000;
    {l, a, r, b} = 4'b0000;
    @(negedge clk);

    // Reset, lock into game, buttons ignored afterwards.
    step("reset", 1'b1, 1'b0, 4'b0000, 4'b0000);
    check("reset_const", redLED, C_HOME);
    idle("idle_after_reset", 1);
    step("start", 1'b0, 1'b1, 4'b0000, 4'b0000);
    check("start_const", redLED, 1'b0);
    step("game_left", 1'b0, 1'b0, 4'b1000, 4'b0010);
    check("game_left_const", redLED, 1'b0);

    // Each entry direction from SETUP_OFF.
    step("rst", 1'b1, 1'b0, 4'b0000, 4'b0000);
    step("rst_off", 1'b0, 1'b0, 4'b1000, 4'b0000);
    step("enter_left", 1'b0, 1'b0, 4'b1000, 4'b0010);
    step("rst", 1'b1, 1'b0, 4'b0000, 4'b0000);
    step("rst_off", 1'b0, 1'b0, 4'b1000, 4'b0000);
    step("enter_right", 1'b0, 1'b0, 4'b0100, 4'b1000);
    step("rst", 1'b1, 1'b0, 4'b0000, 4'b0000);
    step("rst_off", 1'b0, 1'b0, 4'b1000, 4'b0000);
    step("enter_down", 1'b0, 1'b0, 4'b0001, 4'b0100);
    step("rst", 1'b1, 1'b0, 4'b0000, 4'b0000);
    step("rst_off", 1'b0, 1'b0, 4'b1000, 4'b0000);
    step("enter_up", 1'b0, 1'b0, 4'b0010, 4'b0001);
    check("enter_up_const", redLED, 1'b1);

    // Exits: any single press leaves, regardless of neighbours.
    step("exit_right", 1'b0, 1'b0, 4'b0100, 4'b0000);
    check("exit_right_const", redLED, 1'b0);
    step("enter_left2", 1'b0, 1'b0, 4'b1000, 4'b0010);
    step("exit_up", 1'b0, 1'b0, 4'b0010, 4'b1111);
    step("enter_right2", 1'b0, 1'b0, 4'b0100, 4'b1000);
    step("exit_left", 1'b0, 1'b0, 4'b1000, 4'b0000);
    step("enter_right3", 1'b0, 1'b0, 4'b0100, 4'b1000);
    step("exit_down", 1'b0, 1'b0, 4'b0001, 4'b0000);

    // Hold then lock; held buttons stay ignored in game.
    step("enter_right4", 1'b0, 1'b0, 4'b0100, 4'b1000);
    idle("hold_on", 4);
    check("hold_on_const", redLED, 1'b1);
    step("start_from_on", 1'b0, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) step("game_held_left", 1'b0, 1'b0, 4'b1000, 4'b0010);

    // Multi-button presses are no press in either setup state.
    step("rst", 1'b1, 1'b0, 4'b0000, 4'b0000);
    step("rst_off", 1'b0, 1'b0, 4'b1000, 4'b0000);
    step("multi_off", 1'b0, 1'b0, 4'b1010, 4'b0011);
    check("multi_off_const", redLED, 1'b0);
    step("enter_left3", 1'b0, 1'b0, 4'b1000, 4'b0010);
    step("multi_on", 1'b0, 1'b0, 4'b1010, 4'b0011);
    check("multi_on_const", redLED, 1'b1);
    step("reset_mid", 1'b1, 1'b0, 4'b1000, 4'b0010);
    step("home_left", 1'b0, 1'b0, 4'b1000, 4'b0000);

    // Random traffic, biased toward single presses with rare start/reset.
    for (int i = 0; i < 3000; i++) begin
      bit rst_b, start_b;
      bit [3:0] btn, nb;
      int mode;
      rst_b   = ($urandom_range(0, 99) < 2);
      start_b = ($urandom_range(0, 99) < 2);
      nb      = 4'($urandom);
      mode    = $urandom_range(0, 9);
      if (mode < 5)      btn = 4'b0001 << $urandom_range(0, 3);
      else if (mode < 7) btn = 4'b0000;
      else               btn = 4'($urandom);
      step("random", rst_b, start_b, btn, nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
